// File: rtl/parallel_to_serial_bits.sv
`default_nettype none
// ============================================================================
// Module      : parallel_to_serial_bits
// Description : Accepts W-bit parallel words over a valid/ready handshake and
//               emits them MSB first as a gapless serial bit stream with a
//               per-bit valid and a last-bit marker. A one-entry holding
//               register lets the next word be accepted while the current
//               word is still shifting, so back-to-back words leave no gap.
// Revision    : 1.0 - initial release
// ============================================================================
module parallel_to_serial_bits #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         ser_valid,
    output logic         ser_data,
    output logic         ser_last
);

    // Counter just wide enough to index every bit of a word.
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [CW-1:0] c_CNT_ZERO = '0;
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(W - 1);

    // Two-state controller: IDLE waits for a word, SHIFT emits one bit/cycle.
    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SHIFT = 1'b1;

    logic [0:0]    r_state;
    logic [W-1:0]  r_sr;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_hold;
    logic          r_hold_valid;

    logic          w_hs;
    logic          w_shifting;
    logic          w_last_bit;

    // Ready only while the holding register is free; forced low during reset
    // so nothing is accepted while state is being cleared.
    assign up_ready   = ~r_hold_valid & ~rst;
    assign w_hs       = up_valid & up_ready;

    assign w_shifting = (r_state == c_SHIFT);
    assign w_last_bit = w_shifting && (r_cnt == c_CNT_LAST);

    assign ser_valid  = w_shifting;
    assign ser_data   = r_sr[W-1];
    assign ser_last   = w_last_bit;

    // Controller, shift register and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_sr    <= '0;
            r_cnt   <= c_CNT_ZERO;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_hs) begin
                        r_sr    <= up_data;
                        r_cnt   <= c_CNT_ZERO;
                        r_state <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    if (r_cnt != c_CNT_LAST) begin
                        r_sr  <= {r_sr[W-2:0], 1'b0};
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end else if (r_hold_valid) begin
                        // Next word was parked earlier: continue without a gap.
                        r_sr  <= r_hold;
                        r_cnt <= c_CNT_ZERO;
                    end else if (w_hs) begin
                        // Word arrived on the last-bit cycle: bypass the hold.
                        r_sr  <= up_data;
                        r_cnt <= c_CNT_ZERO;
                    end else begin
                        // Shift the final bit out so ser_data idles low.
                        r_sr    <= {r_sr[W-2:0], 1'b0};
                        r_cnt   <= c_CNT_ZERO;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= c_CNT_ZERO;
                end
            endcase
        end
    end

    // Holding register: captures a word accepted mid-word, drains at word end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else if (w_shifting && !w_last_bit && w_hs) begin
            r_hold       <= up_data;
            r_hold_valid <= 1'b1;
        end else if (w_last_bit && r_hold_valid) begin
            r_hold_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parallel_to_serial_bits.sv
`default_nettype none
// ============================================================================
// Module      : tb_parallel_to_serial_bits
// Description : Directed self-checking bench for parallel_to_serial_bits
//               (W = 8). Expected streams are hand-derived from the words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parallel_to_serial_bits;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         up_valid;
    logic         up_ready;
    logic [W-1:0] up_data;
    logic         ser_valid;
    logic         ser_data;
    logic         ser_last;

    int n_checks;
    int n_errors;

    parallel_to_serial_bits #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .up_data   (up_data),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_last  (ser_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 110011 detector fed only with valid serial bits.
    logic       det_en;
    logic [5:0] det_win;
    int         det_bits;
    int         det_hits;
    int         det_pos [4];

    // Sample the stream away from the active edge; clear while disabled.
    always @(negedge clk) begin
        if (!det_en) begin
            det_win  <= '0;
            det_bits <= 0;
            det_hits <= 0;
        end else if (ser_valid) begin
            det_win  <= {det_win[4:0], ser_data};
            det_bits <= det_bits + 1;
            if (({det_win[4:0], ser_data} == 6'b110011) && (det_bits + 1 >= 6)) begin
                if (det_hits < 4) det_pos[det_hits] <= det_bits + 1;
                det_hits <= det_hits + 1;
            end
        end
    end

    // Single comparison point: counts and reports.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, advance to next cycle.
    task automatic run_cycle(input string name, input int c,
                             input logic v, input logic [W-1:0] d,
                             input logic er, input logic ev,
                             input logic ed, input logic el);
        up_valid = v;
        up_data  = d;
        @(negedge clk);
        chk($sformatf("%s c%0d ready", name, c), up_ready, er);
        chk($sformatf("%s c%0d valid", name, c), ser_valid, ev);
        if (ev) chk($sformatf("%s c%0d data", name, c), ser_data, ed);
        chk($sformatf("%s c%0d last", name, c), ser_last, el);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] s;
        logic [7:0]  w;
        n_checks = 0;
        n_errors = 0;
        det_en   = 1'b0;
        up_valid = 1'b0;
        up_data  = '0;
        rst      = 1'b0;
        #1 rst   = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ready", up_ready, 1'b0);
        chk("reset valid", ser_valid, 1'b0);
        chk("reset data", ser_data, 1'b0);
        chk("reset last", ser_last, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single word 0xCC: bits 1,1,0,0,1,1,0,0 in cycles 1..8
        w = 8'hCC;
        for (int c = 0; c <= 9; c++)
            run_cycle("single", c, c == 0, w, 1'b1, (c >= 1 && c <= 8),
                      (c >= 1 && c <= 8) ? w[8-c] : 1'b0, c == 8);

        // Back-to-back via hold; junk data held valid while not ready
        s = {8'hCC, 8'h33};
        for (int c = 0; c <= 17; c++)
            run_cycle("b2b", c, c <= 8,
                      (c == 0) ? 8'hCC : (c == 1) ? 8'h33 : 8'h5A,
                      (c <= 1 || c >= 9), (c >= 1 && c <= 16),
                      (c >= 1 && c <= 16) ? s[16-c] : 1'b0,
                      (c == 8 || c == 16));

        // Direct load on the last-bit cycle
        s = {8'hCC, 8'hF0};
        for (int c = 0; c <= 17; c++)
            run_cycle("direct", c, (c == 0 || c == 8),
                      (c == 0) ? 8'hCC : 8'hF0, 1'b1, (c >= 1 && c <= 16),
                      (c >= 1 && c <= 16) ? s[16-c] : 1'b0,
                      (c == 8 || c == 16));

        // Asynchronous reset during bit 4 of 0xCC with 0x33 parked in hold
        s = {8'hCC, 8'h33};
        for (int c = 0; c <= 3; c++)
            run_cycle("rstmid", c, c <= 1, (c == 0) ? 8'hCC : 8'h33,
                      c <= 1, c >= 1, (c >= 1) ? s[16-c] : 1'b0, 1'b0);
        up_valid = 1'b0;
        chk("rstmid bit4 valid", ser_valid, 1'b1);
        chk("rstmid bit4 data", ser_data, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rstmid async valid", ser_valid, 1'b0);
        chk("rstmid async data", ser_data, 1'b0);
        chk("rstmid async last", ser_last, 1'b0);
        chk("rstmid async ready", up_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c <= 3; c++)
            run_cycle("postrst idle", c, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        w = 8'hAA;
        for (int c = 0; c <= 9; c++)
            run_cycle("postrst AA", c, c == 0, w, 1'b1, (c >= 1 && c <= 8),
                      (c >= 1 && c <= 8) ? w[8-c] : 1'b0, c == 8);

        // Downstream detector: 0xCC, idle gap, 0xCC -> hits at bits 6, 10, 14
        det_en = 1'b1;
        w = 8'hCC;
        for (int c = 0; c <= 21; c++)
            run_cycle("det", c, (c == 0 || c == 12), w, 1'b1,
                      ((c >= 1 && c <= 8) || (c >= 13 && c <= 20)),
                      (c >= 1 && c <= 8) ? w[8-c] :
                      (c >= 13 && c <= 20) ? w[20-c] : 1'b0,
                      (c == 8 || c == 20));
        chk("det bits", det_bits, 16);
        chk("det hits", det_hits, 3);
        chk("det pos0", det_pos[0], 6);
        chk("det pos1", det_pos[1], 10);
        chk("det pos2", det_pos[2], 14);
        det_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parallel_to_serial_bits.md
PARALLEL_TO_SERIAL_BITS -- requirements
Module: parallel_to_serial_bits

Interface
REQ-001 Parameter: W, default 8, word width in bits; legal W >= 2.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 up_valid  input  1  upstream word valid.
REQ-005 up_ready  output  1  block can accept a word this cycle.
REQ-006 up_data  input  W  parallel word, sampled on handshake (up_valid & up_ready).
REQ-007 ser_valid  output  1  ser_data carries a valid bit this cycle.
REQ-008 ser_data  output  1  serial bit stream, feeds a sequence detector's bit input.
REQ-009 ser_last  output  1  high with the final (LSB) bit of each word.

Function
REQ-010 Storage SHALL be: shift register sr[W-1:0], bit counter cnt of width $clog2(W), one-entry holding register hold[W-1:0] with flag hold_valid, and two-state FSM {IDLE, SHIFT}.
REQ-011 Words SHALL be serialized MSB first: ser_data = sr[W-1].
REQ-012 ser_valid SHALL be 1 exactly when state == SHIFT; ser_last SHALL be (state == SHIFT) & (cnt == W-1).
REQ-013 up_ready SHALL be ~hold_valid, and 0 while rst is asserted.
REQ-014 IDLE + handshake: sr <= up_data, cnt <= 0, state <= SHIFT; first bit appears on ser_data the cycle after the handshake (latency 1).
REQ-015 IDLE without handshake: state, sr, cnt SHALL hold.
REQ-016 SHIFT, cnt < W-1: sr shifts left one bit (LSB filled with 0), cnt increments; a handshake in this cycle SHALL write hold <= up_data, hold_valid <= 1.
REQ-017 SHIFT, cnt == W-1, hold_valid == 1: sr <= hold, cnt <= 0, hold_valid <= 0, stay SHIFT (no up_ready since hold is full).
REQ-018 SHIFT, cnt == W-1, hold_valid == 0, handshake: sr <= up_data directly, cnt <= 0, stay SHIFT; hold stays empty.
REQ-019 SHIFT, cnt == W-1, hold_valid == 0, no handshake: state <= IDLE.
REQ-020 Back-to-back words SHALL produce a gapless bit stream: ser_valid stays 1 across word boundaries when the next word is in hold or handshakes on the last-bit cycle.
REQ-021 No word SHALL be lost or duplicated; at most two words in flight (sr + hold).
REQ-022 up_data changes while up_ready == 0 SHALL have no effect.

Reset
REQ-023 Asserting rst at any time, including mid-word, SHALL immediately force state = IDLE, cnt = 0, sr = 0, hold_valid = 0, hold = 0; ser_valid = 0, ser_data = 0, ser_last = 0.
REQ-024 Any partially serialized word and any held word SHALL be discarded on reset; after rst deasserts, up_ready = 1 and the next handshake follows REQ-014.

Verification
REQ-025 W=8, single handshake up_data=8'hCC in cycle 0 -> cycles 1..8 ser_valid=1, ser_data=1,1,0,0,1,1,0,0, ser_last=1 only in cycle 8; cycle 9 ser_valid=0.
REQ-026 W=8, up_valid held high with 8'hCC then 8'h33 -> A accepted cycle 0, B accepted cycle 1 into hold, up_ready=0 cycles 2..8, ser_valid=1 continuously cycles 1..16, stream 11001100 00110011, ser_last in cycles 8 and 16.
REQ-027 W=8, second word 8'hF0 presented only in cycle 8 (last bit of 8'hCC, hold empty) -> direct load, cycle 9 ser_data=1, no gap, up_ready=1 throughout.
REQ-028 Reset asserted asynchronously mid-cycle during bit 4 of 8'hCC with 8'h33 in hold -> outputs 0 at once, no bits of either word emitted after release; new word 8'hAA after release -> 1,0,1,0,1,0,1,0.
REQ-029 Downstream check: serialized stream of words 8'hCC, 8'hCC fed to the 110011 detector bit input -> detector fires exactly on matching positions, with ser_valid gaps never inserting bits.
